muldiv_unit: RTL

- Iterative multiply/divide unit in the execute stage, directly downstream of the register file read ports.
- Source operands come from the register file's rs/rt read data (radata, rbdata). Results are held in architectural HI/LO registers.
- HI/LO return to the register file write-data mux via MFHI/MFLO.
- Supports MULT, MULTU, DIV, DIVU, MTHI and MTLO. Uses a start/busy/done handshake so the control FSM stalls while an operation is in flight.

---
 rtl/muldiv_if.sv | 32 +++
 rtl/muldiv_unit.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/muldiv_if.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_if
// Description : Operation/result bundle between the execute stage and the
//               iterative multiply/divide unit.
// Revision    : 1.0
// ============================================================================
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             mthi;
    logic             mtlo;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, mthi, mtlo,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, mthi, mtlo,
        output busy, done, hi, lo
    );
endinterface
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative MULT/MULTU/DIV/DIVU with HI/LO registers, MTHI/MTLO.
// Revision    : 1.0
// ============================================================================
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CW    = 5
) (
    input  logic     clk,
    input  logic     rst_n,
    muldiv_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             is_div_q, is_div_d;
    logic             neg_res_q, neg_res_d;
    logic             neg_rem_q, neg_rem_d;
    logic             divz_q, divz_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             w_signed;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH:0]   w_add;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;
    logic             w_ge;
    logic [2*WIDTH-1:0] w_prod;

    assign w_signed = ~bus.op[0];
    assign w_a_neg  = w_signed & bus.a[WIDTH-1];
    assign w_b_neg  = w_signed & bus.b[WIDTH-1];
    assign w_a_mag  = w_a_neg ? -bus.a : bus.a;
    assign w_b_mag  = w_b_neg ? -bus.b : bus.b;

    // Multiply: acc_lo holds the remaining multiplier bits, product shifts in from the top.
    assign w_add    = {1'b0, acc_hi_q} + {1'b0, (acc_lo_q[0] ? opb_q : {WIDTH{1'b0}})};

    // Divide: partial remainder stays below the divisor, so bit WIDTH of the difference is the borrow.
    assign w_shift  = {acc_hi_q, acc_lo_q[WIDTH-1]};
    assign w_diff   = w_shift - {1'b0, opb_q};
    assign w_ge     = ~w_diff[WIDTH];

    assign w_prod   = neg_res_q ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        divz_d    = divz_q;
        opb_d     = opb_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d   = S_RUN;
                    cnt_d     = '0;
                    busy_d    = 1'b1;
                    is_div_d  = bus.op[1];
                    neg_res_d = w_a_neg ^ w_b_neg;
                    neg_rem_d = w_a_neg;
                    divz_d    = (bus.b == '0);
                    opb_d     = w_b_mag;
                    acc_hi_d  = '0;
                    acc_lo_d  = w_a_mag;
                end else begin
                    if (bus.mthi) hi_d = bus.a;
                    if (bus.mtlo) lo_d = bus.a;
                end
            end
            S_RUN: begin
                cnt_d = cnt_q + 1'b1;
                if (is_div_q) begin
                    acc_hi_d = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
                    acc_lo_d = {acc_lo_q[WIDTH-2:0], w_ge};
                end else begin
                    acc_hi_d = w_add[WIDTH:1];
                    acc_lo_d = {w_add[0], acc_lo_q[WIDTH-1:1]};
                end
                if (cnt_q == CW'(WIDTH-1)) state_d = S_FIX;
            end
            S_FIX: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                if (is_div_q) begin
                    // Divide by zero leaves |a| as remainder; re-signing it restores a.
                    lo_d = divz_q ? {WIDTH{1'b1}} : (neg_res_q ? -acc_lo_q : acc_lo_q);
                    hi_d = neg_rem_q ? -acc_hi_q : acc_hi_q;
                end else begin
                    hi_d = w_prod[2*WIDTH-1:WIDTH];
                    lo_d = w_prod[WIDTH-1:0];
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            divz_q    <= 1'b0;
            opb_q     <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            divz_q    <= divz_d;
            opb_q     <= opb_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule
`default_nettype wire
